// File: rtl/id_redirect_unit_pkg.sv
// id_redirect_unit_pkg: shared decode constants, FSM encoding and target helpers
// for the ID-stage branch/jump redirect unit.
package id_redirect_unit_pkg;

  // Primary opcodes of the control-transfer instructions resolved in ID
  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  // SPECIAL funct for jr, and REGIMM rt selectors for bltz/bgez
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // PC-relative branch target; wraps at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Pseudo-absolute jump target within the current 256 MB region
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] target);
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/id_redirect_unit_branch_compare.sv
// branch_compare: combinational branch condition evaluator for the ID stage.
module branch_compare
  import id_redirect_unit_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        taken
);

  logic rs_neg_s;
  logic rs_zero_s;

  assign rs_neg_s  = rs_data[31];
  assign rs_zero_s = (rs_data == 32'd0);

  // Evaluate the condition of the branch selected by opcode (and rt for REGIMM)
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (rs_data == rt_data);
      OP_BNE:  taken = (rs_data != rt_data);
      OP_BLEZ: taken = rs_neg_s | rs_zero_s;
      OP_BGTZ: taken = ~rs_neg_s & ~rs_zero_s;
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          taken = rs_neg_s;
        end else if (rt == RT_BGEZ) begin
          taken = ~rs_neg_s;
        end else begin
          taken = 1'b0;
        end
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_redirect_unit.sv
// id_redirect_unit: decodes the IF/ID instruction, resolves branches/jumps in ID,
// drives the IF PC-select controls, stalls on operand hazards and flushes IF/ID
// after a taken redirect.
// Optional build macro ID_REDIRECT_STATS_EN adds taken-redirect and stall-cycle
// counters on oTakenCount / oStallCount.
module id_redirect_unit
  import id_redirect_unit_pkg::*;
#(
  parameter int unsigned STALL_MAX = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] iInstruction,
  input  logic [31:0] iPCPlus4,
  input  logic [31:0] iRsData,
  input  logic [31:0] iRtData,
  input  logic        iEXRegWrite,
  input  logic        iEXMemRead,
  input  logic [4:0]  iEXWriteReg,
  input  logic        iMEMMemRead,
  input  logic [4:0]  iMEMWriteReg,
  output logic        cPCSrc,
  output logic [31:0] PCSumImm,
  output logic        cPCMux,
  output logic [31:0] ReadReg1,
  output logic        oStall,
  output logic        oFlushIFID,
  output logic        oHazardErr
`ifdef ID_REDIRECT_STATS_EN
  ,
  output logic [31:0] oTakenCount,
  output logic [31:0] oStallCount
`endif
);

  // True when register r is about to be written by an instruction still in flight
  function automatic logic pending_write(input logic [4:0] r,
                                         input logic       ex_reg_write,
                                         input logic [4:0] ex_write_reg,
                                         input logic       mem_mem_read,
                                         input logic [4:0] mem_write_reg);
    return (r != 5'd0) &&
           ((ex_reg_write && (ex_write_reg == r)) ||
            (mem_mem_read && (mem_write_reg == r)));
  endfunction

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [5:0]  funct_s;
  logic        is_beq_bne_s;
  logic        is_branch_s;
  logic        is_jump_s;
  logic        is_jr_s;
  logic        cmp_taken_s;
  logic        ctrl_taken_s;
  logic        hazard_s;
  logic [31:0] target_s;

  state_e      state_r;
  state_e      state_next_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_next_s;
  logic        reach_s;
  logic        err_r;
  logic        src_s;
  logic        mux_s;
  logic        stall_s;
  logic        flush_s;

  // An EX load always asserts iEXRegWrite as well, so the load flag adds nothing
  logic        unused_s;
  assign unused_s = iEXMemRead;

  assign opcode_s = iInstruction[31:26];
  assign rs_s     = iInstruction[25:21];
  assign rt_s     = iInstruction[20:16];
  assign funct_s  = iInstruction[5:0];

  assign is_beq_bne_s = (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
  assign is_branch_s  = is_beq_bne_s ||
                        (opcode_s == OP_BLEZ) || (opcode_s == OP_BGTZ) ||
                        ((opcode_s == OP_REGIMM) &&
                         ((rt_s == RT_BLTZ) || (rt_s == RT_BGEZ)));
  assign is_jump_s    = (opcode_s == OP_J) || (opcode_s == OP_JAL);
  assign is_jr_s      = (opcode_s == OP_SPECIAL) && (funct_s == FN_JR);

  branch_compare u_branch_compare (
    .opcode  (opcode_s),
    .rt      (rt_s),
    .rs_data (iRsData),
    .rt_data (iRtData),
    .taken   (cmp_taken_s)
  );

  assign ctrl_taken_s = is_jump_s || is_jr_s || (is_branch_s && cmp_taken_s);

  // Jumps never read registers; only branches and jr can be held up
  assign hazard_s = (is_branch_s || is_jr_s) &&
                    (pending_write(rs_s, iEXRegWrite, iEXWriteReg,
                                   iMEMMemRead, iMEMWriteReg) ||
                     (is_beq_bne_s &&
                      pending_write(rt_s, iEXRegWrite, iEXWriteReg,
                                    iMEMMemRead, iMEMWriteReg)));

  assign target_s = is_jump_s ? jump_target(iPCPlus4, iInstruction[25:0])
                              : branch_target(iPCPlus4, iInstruction[15:0]);

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control outputs; HOLD resolves exactly like IDLE once clear
  always_comb begin
    state_next_s = state_r;
    src_s        = 1'b0;
    mux_s        = 1'b0;
    stall_s      = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      IDLE, HOLD: begin
        if (hazard_s) begin
          stall_s      = 1'b1;
          state_next_s = HOLD;
        end else if (ctrl_taken_s) begin
          if (is_jr_s) begin
            mux_s = 1'b1;
          end else begin
            src_s = 1'b1;
          end
          flush_s      = 1'b1;
          state_next_s = FLUSH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FLUSH:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign cnt_next_s = (cnt_r == 2'd3) ? 2'd3 : (cnt_r + 2'd1);
  assign reach_s    = (32'(cnt_next_s) >= STALL_MAX);

  // Saturating stall counter and sticky error; both clear on every IDLE entry
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r <= 2'd0;
      err_r <= 1'b0;
    end else if (state_next_s == IDLE) begin
      cnt_r <= 2'd0;
      err_r <= 1'b0;
    end else if (stall_s) begin
      cnt_r <= cnt_next_s;
      err_r <= err_r | reach_s;
    end else begin
      cnt_r <= cnt_r;
      err_r <= err_r;
    end
  end

  // Outputs are held at zero while reset is low and during the FLUSH bubble
  assign cPCSrc     = Reset & src_s;
  assign cPCMux     = Reset & mux_s;
  assign oStall     = Reset & stall_s;
  assign oFlushIFID = Reset & flush_s;
  assign oHazardErr = err_r;
  assign PCSumImm   = (Reset && (state_r != FLUSH)) ? target_s : 32'd0;
  assign ReadReg1   = (Reset && (state_r != FLUSH)) ? iRsData  : 32'd0;

`ifdef ID_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_r;
  logic [31:0] stall_cnt_r;

  // Wrapping event counters for taken redirects and stall cycles
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      taken_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      taken_cnt_r <= taken_cnt_r + {31'd0, flush_s};
      stall_cnt_r <= stall_cnt_r + {31'd0, stall_s};
    end
  end

  assign oTakenCount = taken_cnt_r;
  assign oStallCount = stall_cnt_r;
`endif

endmodule
